seq_tx: RTL and testbench

Serial pattern transmitter: the source side of the single-bit `din`/`dout` stream consumed by the team's Moore sequence detectors. It captures a parallel pattern on a start request and shifts it out MSB-first, one bit per clock. The pattern can be repeated a programmable number of times, with idle gap bits between repetitions. It drives detector inputs in loopback benches and serial links in the design.

---
 rtl/seq_tx.sv | 152 +++++++++++++++
 tb/tb_seq_tx.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_tx.sv
// Serial pattern transmitter: shifts a latched pattern out MSB-first, repeated rpt+1 times with GAP idle bits between.
// Latency: first bit registered on dout one cycle after start is sampled; no backpressure, start only accepted in IDLE.
module seq_tx #(
  parameter int   WIDTH    = 8,
  parameter int   CNT_W    = 4,
  parameter int   GAP      = 1,
  parameter logic IDLE_BIT = 1'b1
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         start,
  input  logic                         abort,
  input  logic [WIDTH-1:0]             pattern,
  input  logic [$clog2(WIDTH+1)-1:0]   len,
  input  logic [CNT_W-1:0]             rpt,
  output logic                         dout,
  output logic                         dout_valid,
  output logic                         busy,
  output logic                         done
);

  localparam int LEN_W = $clog2(WIDTH+1);
  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int GAP_W = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_GAP   = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t             r_state, w_state_nxt;
  logic [WIDTH-1:0]   r_shadow, w_shadow_nxt;
  logic [IDX_W-1:0]   r_top, w_top_nxt;
  logic [IDX_W-1:0]   r_idx, w_idx_nxt;
  logic [CNT_W-1:0]   r_rpt, w_rpt_nxt;
  logic [GAP_W-1:0]   r_gap, w_gap_nxt;
  logic               r_dout, w_dout_nxt;
  logic               r_valid, w_valid_nxt;
  logic               r_busy, w_busy_nxt;
  logic               r_done, w_done_nxt;

  logic [LEN_W-1:0]   w_len_eff;
  logic [IDX_W-1:0]   w_len_top;

  // 0 and out-of-range lengths both mean a full-width pattern.
  assign w_len_eff = ((len == '0) || (len > LEN_MAX)) ? LEN_MAX : len;
  assign w_len_top = IDX_W'(w_len_eff - LEN_W'(1));

  always_comb begin
    w_state_nxt  = r_state;
    w_shadow_nxt = r_shadow;
    w_top_nxt    = r_top;
    w_idx_nxt    = r_idx;
    w_rpt_nxt    = r_rpt;
    w_gap_nxt    = r_gap;
    w_dout_nxt   = IDLE_BIT;
    w_valid_nxt  = 1'b0;
    w_busy_nxt   = 1'b0;
    w_done_nxt   = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (start && !abort) begin
          w_state_nxt  = S_SHIFT;
          w_shadow_nxt = pattern;
          w_top_nxt    = w_len_top;
          w_idx_nxt    = w_len_top;
          w_rpt_nxt    = rpt;
          w_gap_nxt    = '0;
        end
      end
      S_SHIFT: begin
        if (abort) begin
          w_state_nxt = S_IDLE;
        end else if (r_idx == '0) begin
          if (r_rpt != '0) begin
            w_rpt_nxt = r_rpt - CNT_W'(1);
            if (GAP > 0) begin
              w_state_nxt = S_GAP;
              w_gap_nxt   = GAP_W'(GAP - 1);
            end else begin
              w_idx_nxt = r_top;
            end
          end else begin
            w_state_nxt = S_DONE;
          end
        end else begin
          w_idx_nxt = r_idx - IDX_W'(1);
        end
      end
      S_GAP: begin
        if (abort) begin
          w_state_nxt = S_IDLE;
        end else if (r_gap == '0) begin
          w_state_nxt = S_SHIFT;
          w_idx_nxt   = r_top;
        end else begin
          w_gap_nxt = r_gap - GAP_W'(1);
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    // Outputs are registered from the next state so dout lines up with the state it belongs to.
    w_valid_nxt = (w_state_nxt == S_SHIFT);
    w_busy_nxt  = (w_state_nxt != S_IDLE);
    w_done_nxt  = (w_state_nxt == S_DONE);
    if (w_valid_nxt) begin
      w_dout_nxt = w_shadow_nxt[w_idx_nxt];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= S_IDLE;
      r_shadow <= '0;
      r_top    <= '0;
      r_idx    <= '0;
      r_rpt    <= '0;
      r_gap    <= '0;
      r_dout   <= IDLE_BIT;
      r_valid  <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_shadow <= w_shadow_nxt;
      r_top    <= w_top_nxt;
      r_idx    <= w_idx_nxt;
      r_rpt    <= w_rpt_nxt;
      r_gap    <= w_gap_nxt;
      r_dout   <= w_dout_nxt;
      r_valid  <= w_valid_nxt;
      r_busy   <= w_busy_nxt;
      r_done   <= w_done_nxt;
    end
  end

  assign dout       = r_dout;
  assign dout_valid = r_valid;
  assign busy       = r_busy;
  assign done       = r_done;

endmodule

// File: tb/tb_seq_tx.sv
// Bench for seq_tx: directed scenarios plus random traffic against a queue-based reference model.
module tb_seq_tx;

  localparam int   WIDTH    = 8;
  localparam int   CNT_W    = 4;
  localparam int   GAP      = 1;
  localparam logic IDLE_BIT = 1'b1;
  localparam int   LEN_W    = $clog2(WIDTH+1);

  logic             clk;
  logic             reset_n;
  logic             start;
  logic             abort;
  logic [WIDTH-1:0] pattern;
  logic [LEN_W-1:0] len;
  logic [CNT_W-1:0] rpt;
  logic             dout;
  logic             dout_valid;
  logic             busy;
  logic             done;

  seq_tx #(
    .WIDTH    (WIDTH),
    .CNT_W    (CNT_W),
    .GAP      (GAP),
    .IDLE_BIT (IDLE_BIT)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .abort      (abort),
    .pattern    (pattern),
    .len        (len),
    .rpt        (rpt),
    .dout       (dout),
    .dout_valid (dout_valid),
    .busy       (busy),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Expected per-cycle output: dout, dout_valid, done.
  typedef struct packed {
    logic d;
    logic v;
    logic dn;
  } ent_t;

  ent_t exp_q[$];
  ent_t cur;
  logic cur_busy;

  task automatic model_idle();
    exp_q.delete();
    cur      = {IDLE_BIT, 1'b0, 1'b0};
    cur_busy = 1'b0;
  endtask

  // Whole transfer expanded up front from the timing rules: bits, gaps, then the done cycle.
  task automatic model_build();
    int L;
    L = ((len == 0) || (len > WIDTH)) ? WIDTH : int'(len);
    for (int j = 0; j <= int'(rpt); j++) begin
      for (int k = 0; k < L; k++) exp_q.push_back({pattern[L-1-k], 1'b1, 1'b0});
      if (j < int'(rpt))
        for (int g = 0; g < GAP; g++) exp_q.push_back({IDLE_BIT, 1'b0, 1'b0});
    end
    exp_q.push_back({IDLE_BIT, 1'b0, 1'b1});
  endtask

  task automatic model_edge();
    if (!reset_n) begin
      model_idle();
    end else if (cur_busy) begin
      if (abort) model_idle();
      else if (exp_q.size() > 0) cur = exp_q.pop_front();
      else model_idle();
    end else if (start && !abort) begin
      model_build();
      cur      = exp_q.pop_front();
      cur_busy = 1'b1;
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check("dout", dout, cur.d);
    check("dout_valid", dout_valid, cur.v);
    check("busy", busy, cur_busy);
    check("done", done, cur.dn);
  endtask

  logic [7:0] cap, capv;
  int n_done;

  initial begin
    reset_n = 1'b0;
    start   = 1'b0;
    abort   = 1'b0;
    pattern = '0;
    len     = '0;
    rpt     = '0;
    model_idle();
    repeat (2) @(negedge clk);
    check("rst_dout", dout, 1);
    check("rst_valid", dout_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    reset_n = 1'b1;
    cycle();

    // Single 8-bit send of A5.
    pattern = 8'hA5; len = 4'd8; rpt = '0; start = 1'b1;
    cap = '0;
    for (int i = 0; i < 8; i++) begin
      cycle();
      start = 1'b0;
      cap = {cap[6:0], dout};
    end
    check("a5_bits", cap, 8'hA5);
    cycle();
    check("a5_done", done, 1);
    cycle();
    check("a5_busy_low", busy, 0);

    // Two-bit pattern repeated three times with one gap bit.
    pattern = 8'h02; len = 4'd2; rpt = 4'd2; start = 1'b1;
    cap = '0; capv = '0;
    for (int i = 0; i < 8; i++) begin
      cycle();
      start = 1'b0;
      cap  = {cap[6:0], dout};
      capv = {capv[6:0], dout_valid};
    end
    check("rpt_bits", cap, 8'hB6);
    check("rpt_valid", capv, 8'hDB);
    cycle();
    check("rpt_done", done, 1);
    cycle();

    // len=0 means full width.
    pattern = 8'h81; len = 4'd0; rpt = '0; start = 1'b1;
    cap = '0;
    for (int i = 0; i < 8; i++) begin
      cycle();
      start = 1'b0;
      cap = {cap[6:0], dout};
    end
    check("len0_bits", cap, 8'h81);
    cycle();
    cycle();

    // Start while busy is ignored; restart in the first IDLE cycle.
    pattern = 8'h3C; len = 4'd8; rpt = '0; start = 1'b1;
    cycle();
    start = 1'b0;
    cycle();
    cycle();
    start = 1'b1; pattern = 8'hFF; len = 4'd3; rpt = 4'd5;
    cycle();
    start = 1'b0;
    n_done = 0;
    for (int i = 0; i < 20; i++) begin
      cycle();
      if (done) n_done++;
      if (!busy) break;
    end
    check("busy_start_one_done", n_done, 1);
    check("busy_start_idle", busy, 0);
    pattern = 8'hC3; len = 4'd8; rpt = '0; start = 1'b1;
    cycle();
    start = 1'b0;
    check("restart_valid", dout_valid, 1);
    check("restart_first_bit", dout, 1);
    repeat (10) cycle();

    // Abort during bit 3 of 8.
    pattern = 8'h0F; len = 4'd8; rpt = 4'd1; start = 1'b1;
    cycle();
    start = 1'b0;
    repeat (3) cycle();
    abort = 1'b1;
    cycle();
    abort = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_valid", dout_valid, 0);
    check("abort_dout", dout, 1);
    n_done = 0;
    for (int i = 0; i < 12; i++) begin
      cycle();
      if (done) n_done++;
    end
    check("abort_no_done", n_done, 0);

    // Abort and start together in SHIFT.
    pattern = 8'h55; len = 4'd8; rpt = '0; start = 1'b1;
    cycle();
    start = 1'b0;
    cycle();
    abort = 1'b1; start = 1'b1;
    cycle();
    abort = 1'b0; start = 1'b0;
    check("abort_start_busy", busy, 0);
    cycle();
    check("abort_start_not_taken", busy, 0);

    // Asynchronous reset in the middle of a shift.
    pattern = 8'hA5; len = 4'd8; rpt = 4'd3; start = 1'b1;
    cycle();
    start = 1'b0;
    repeat (2) cycle();
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("async_rst_dout", dout, 1);
    check("async_rst_valid", dout_valid, 0);
    check("async_rst_busy", busy, 0);
    check("async_rst_done", done, 0);
    model_idle();
    @(negedge clk);
    repeat (2) cycle();
    reset_n = 1'b1;
    n_done = 0;
    for (int i = 0; i < 12; i++) begin
      cycle();
      if (done) n_done++;
    end
    check("async_rst_no_done", n_done, 0);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      start   = ($urandom_range(0, 3) == 0);
      abort   = ($urandom_range(0, 59) == 0);
      pattern = WIDTH'($urandom);
      len     = LEN_W'($urandom_range(0, 15));
      rpt     = ($urandom_range(0, 9) == 0) ? CNT_W'($urandom_range(0, 15))
                                             : CNT_W'($urandom_range(0, 2));
      cycle();
    end
    start = 1'b0;
    abort = 1'b0;
    repeat (5) cycle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
